// File: rtl/pipeline_debug_controller.sv
// -----------------------------------------------------------------------------
// pipeline_debug_controller
//
// Host-side sequencer for the pipelined MIPS datapath. Command bytes arrive
// from a UART receiver; the controller gates the whole datapath through a
// single clock-enable (continuous run or single step), detects HALT reaching
// WB, counts enabled cycles, and after every step/halt (or on request) dumps
// PC, cycle count, the register bank and a window of data memory over the
// UART transmitter, each 32-bit word MSB byte first.
//
// Commands (only accepted in IDLE, others dropped):
//   'C' (0x43) run until HALT      (ignored once halted)
//   'S' (0x53) single step + dump  (ignored once halted)
//   'D' (0x44) dump only
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_rx_data, i_rx_valid   received byte and its one-cycle strobe
//   o_tx_data, o_tx_start   byte to send and one-cycle send request
//   i_tx_busy               transmitter busy (rises at most one cycle late)
//   o_pipe_en               datapath clock-enable
//   i_halt                  HALT instruction in WB
//   i_pc                    current PC
//   o_reg_addr, i_reg_data  register-bank debug read port
//   o_mem_addr, i_mem_data  data-memory debug read port (word index)
//   o_halted                sticky halt indication
//
// Handshake: o_tx_start is a one-cycle pulse issued only when i_tx_busy is
// low; o_tx_data is held until the transmitter drops busy again. The first
// cycle after the pulse is skipped because busy may still be low there.
//
// Debug visibility: the FSM state is held in the signal "state" (state_t).
// -----------------------------------------------------------------------------
module pipeline_debug_controller #(
  parameter int NBITS      = 32,
  parameter int RBITS      = 5,
  parameter int BANK_SIZE  = 32,
  parameter int DMEM_WORDS = 32,
  parameter int MEMABITS   = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_busy,
  output logic                o_pipe_en,
  input  logic                i_halt,
  input  logic [NBITS-1:0]    i_pc,
  output logic [RBITS-1:0]    o_reg_addr,
  input  logic [NBITS-1:0]    i_reg_data,
  output logic [MEMABITS-1:0] o_mem_addr,
  input  logic [NBITS-1:0]    i_mem_data,
  output logic                o_halted
);

  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  // Dump layout: word 0 = PC, word 1 = cycle count, then registers, then memory.
  localparam int NWORDS = 2 + BANK_SIZE + DMEM_WORDS;
  localparam int WIDX   = $clog2(NWORDS);

  localparam logic [WIDX-1:0] REG_BASE  = WIDX'(2);
  localparam logic [WIDX-1:0] MEM_BASE  = WIDX'(2 + BANK_SIZE);
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(NWORDS - 1);
  localparam logic [1:0]      LAST_BYTE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_WAIT
  } state_t;

  state_t              state;
  logic [NBITS-1:0]    cycle_cnt;
  logic [NBITS-1:0]    shift_q;
  logic [WIDX-1:0]     word_idx;
  logic [1:0]          byte_idx;
  logic                skip_q;
  logic [RBITS-1:0]    reg_addr_q;
  logic [MEMABITS-1:0] mem_addr_q;

  logic [RBITS-1:0]    reg_addr_d;
  logic [MEMABITS-1:0] mem_addr_d;
  logic [WIDX-1:0]     reg_rel;
  logic [WIDX-1:0]     mem_rel;
  logic                in_reg;
  logic                in_mem;
  logic [NBITS-1:0]    sel_word;

  // The debug read addresses must be valid during DUMP_LOAD itself because
  // the bank/memory return data combinationally and it is captured on the
  // same edge. Outside DUMP_LOAD the last used address is held.
  always_comb begin
    reg_rel    = word_idx - REG_BASE;
    mem_rel    = word_idx - MEM_BASE;
    in_reg     = (word_idx >= REG_BASE) && (word_idx < MEM_BASE);
    in_mem     = (word_idx >= MEM_BASE);
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    if (state == DUMP_LOAD) begin
      if (in_reg) reg_addr_d = RBITS'(reg_rel);
      if (in_mem) mem_addr_d = MEMABITS'(mem_rel);
    end
    if (word_idx == '0)
      sel_word = i_pc;
    else if (word_idx == WIDX'(1))
      sel_word = cycle_cnt;
    else if (in_reg)
      sel_word = i_reg_data;
    else
      sel_word = i_mem_data;
  end

  assign o_reg_addr = reg_addr_d;
  assign o_mem_addr = mem_addr_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cycle_cnt  <= '0;
      shift_q    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      skip_q     <= 1'b0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_pipe_en  <= 1'b0;
      o_halted   <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;

      // Counts every enabled cycle, including the one that retires HALT.
      if (o_pipe_en) cycle_cnt <= cycle_cnt + NBITS'(1);

      case (state)
        IDLE: begin
          o_pipe_en <= 1'b0;
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_RUN: begin
                if (!o_halted) begin
                  state     <= RUN;
                  o_pipe_en <= 1'b1;
                end
              end
              CMD_STEP: begin
                if (!o_halted) begin
                  state     <= STEP;
                  o_pipe_en <= 1'b1;
                end
              end
              CMD_DUMP: state <= DUMP_LOAD;
              default:  state <= IDLE;
            endcase
          end
        end

        RUN: begin
          if (i_halt && o_pipe_en) begin
            o_pipe_en <= 1'b0;
            o_halted  <= 1'b1;
            state     <= DUMP_LOAD;
          end
        end

        // Entered with o_pipe_en already high, so this is the single
        // enabled cycle of the step.
        STEP: begin
          o_pipe_en <= 1'b0;
          if (i_halt) o_halted <= 1'b1;
          state <= DUMP_LOAD;
        end

        DUMP_LOAD: begin
          shift_q    <= sel_word;
          byte_idx   <= '0;
          reg_addr_q <= reg_addr_d;
          mem_addr_q <= mem_addr_d;
          state      <= DUMP_SEND;
        end

        DUMP_SEND: begin
          if (!i_tx_busy) begin
            o_tx_data  <= shift_q[NBITS-1 -: 8];
            o_tx_start <= 1'b1;
            skip_q     <= 1'b1;
            state      <= DUMP_WAIT;
          end
        end

        DUMP_WAIT: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!i_tx_busy) begin
            shift_q <= shift_q << 8;
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              if (word_idx == LAST_WORD) begin
                word_idx <= '0;
                state    <= IDLE;
              end else begin
                word_idx <= word_idx + WIDX'(1);
                state    <= DUMP_LOAD;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= DUMP_SEND;
            end
          end
        end

        default: begin
          o_pipe_en <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_debug_controller.
// Reference model: the expected dump is built from the model PC, a model cycle
// count derived from the commands issued, Rn = n*0x01010101 and
// M[k] = 0xA0000000 + k, flattened into a byte queue. A negedge monitor pops
// one byte per o_tx_start and compares.
// -----------------------------------------------------------------------------
module tb_pipeline_debug_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        pipe_en;
  logic        halt = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        halted;

  localparam int DUMP_BYTES = 4 * (2 + 32 + 32);

  pipeline_debug_controller dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_busy  (tx_busy),
    .o_pipe_en  (pipe_en),
    .i_halt     (halt),
    .i_pc       (pc),
    .o_reg_addr (reg_addr),
    .i_reg_data (reg_data),
    .o_mem_addr (mem_addr),
    .i_mem_data (mem_data),
    .o_halted   (halted)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Datapath debug read ports
  assign reg_data = 32'(reg_addr) * 32'h01010101;
  assign mem_data = 32'hA0000000 + 32'(mem_addr);

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          busy_len = 2;
  int          en_cnt = 0;
  int          halt_target = 0;
  int          tx_seen = 0;
  logic        prev_start = 1'b0;
  logic        prev_busy = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_halted = 1'b0;

  // Transmitter model: goes busy right after a start and stays busy busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // Enabled-cycle counter and HALT injection on a chosen enabled cycle.
  always @(negedge clk) begin
    if (pipe_en) en_cnt++;
    if (halt) halt = 1'b0;
    else if (pipe_en && halt_target != 0 && en_cnt == halt_target) halt = 1'b1;
  end

  // Monitor: compares every transmitted byte against the expected queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (tx_start) begin
      tx_seen++;
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL tx_start_back_to_back: got start in consecutive cycles, required gap");
      end
      checks++;
      if (prev_busy) begin
        errors++;
        $display("FAIL tx_start_while_busy: got start with busy=1, required busy=0");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected_byte: got %02h, required no byte", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte: got %02h, required %02h (%0d left)", tx_data, e, exp_q.size());
        end
      end
    end
    prev_start = tx_start;
    prev_busy  = tx_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_dump();
    push_word(pc);
    push_word(m_cnt);
    for (int n = 0; n < 32; n++) push_word(32'(n) * 32'h01010101);
    for (int k = 0; k < 32; k++) push_word(32'hA0000000 + 32'(k));
  endtask

  // Waits for the expected queue to empty, then for the controller to be idle.
  task automatic drain(input string name, input int tx_base);
    int n;
    int limit;
    n = 0;
    limit = DUMP_BYTES * (busy_len + 6) + 200;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_missing_bytes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_byte_count"}, 32'(tx_seen - tx_base), 32'(DUMP_BYTES));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_tx_start"}, 32'(tx_start), 32'd0);
    check({name, "_tx_data"},  32'(tx_data),  32'd0);
    check({name, "_pipe_en"},  32'(pipe_en),  32'd0);
    check({name, "_halted"},   32'(halted),   32'd0);
    check({name, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero(name);
    exp_q.delete();
    m_cnt    = 32'h0;
    m_halted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_step(input string name);
    int e0;
    int t0;
    e0 = en_cnt;
    t0 = tx_seen;
    m_cnt = m_cnt + 32'd1;
    push_dump();
    send(8'h53);
    drain(name, t0);
    check({name, "_pipe_en_cycles"}, 32'(en_cnt - e0), 32'd1);
    check({name, "_halted"}, 32'(halted), 32'(m_halted));
  endtask

  task automatic do_run(input string name, input int n);
    int e0;
    int t0;
    e0 = en_cnt;
    t0 = tx_seen;
    halt_target = en_cnt + n;
    m_cnt    = m_cnt + 32'(n);
    m_halted = 1'b1;
    push_dump();
    send(8'h43);
    drain(name, t0);
    check({name, "_pipe_en_cycles"}, 32'(en_cnt - e0), 32'(n));
    check({name, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic do_dump(input string name);
    int e0;
    int t0;
    e0 = en_cnt;
    t0 = tx_seen;
    push_dump();
    send(8'h44);
    drain(name, t0);
    check({name, "_pipe_en_cycles"}, 32'(en_cnt - e0), 32'd0);
  endtask

  initial begin
    int e0;
    int t0;
    int n;

    // Power-on reset
    rst = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single step from PC 7
    busy_len = 2;
    pc = 32'h00000007;
    do_step("step_pc7");

    // Randomised steps
    for (int i = 0; i < 3; i++) begin
      pc = $urandom();
      busy_len = $urandom_range(1, 4);
      do_step("step_rand");
    end

    // Dump with a 'C' arriving mid-dump, then an unknown byte in IDLE
    e0 = en_cnt;
    t0 = tx_seen;
    push_dump();
    send(8'h44);
    n = 0;
    while (exp_q.size() > DUMP_BYTES - 40 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    send(8'h43);
    drain("dump_mid_c", t0);
    check("dump_mid_c_pipe_en_cycles", 32'(en_cnt - e0), 32'd0);
    e0 = en_cnt;
    t0 = tx_seen;
    send(8'h41);
    repeat (10) @(negedge clk);
    check("byte_41_pipe_en_cycles", 32'(en_cnt - e0), 32'd0);
    check("byte_41_tx_bytes", 32'(tx_seen - t0), 32'd0);
    do_step("step_after_ignored");

    // Fresh run halting on the 10th enabled cycle
    async_reset("reset_before_run");
    repeat (2) @(negedge clk);
    pc = $urandom();
    do_run("run_halt10", 10);

    // Halted: 'C' and 'S' are ignored
    e0 = en_cnt;
    t0 = tx_seen;
    send(8'h43);
    send(8'h53);
    repeat (30) @(negedge clk);
    check("halted_cmds_pipe_en_cycles", 32'(en_cnt - e0), 32'd0);
    check("halted_cmds_tx_bytes", 32'(tx_seen - t0), 32'd0);

    // Slow transmitter dump
    busy_len = 50;
    do_dump("dump_slow_tx");

    // Reset mid-dump, then dump restarts from the PC word with count 0
    busy_len = 2;
    push_dump();
    send(8'h44);
    n = 0;
    while (exp_q.size() > DUMP_BYTES - 25 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    async_reset("reset_mid_dump");
    t0 = tx_seen;
    repeat (20) @(negedge clk);
    check("reset_mid_dump_no_tx", 32'(tx_seen - t0), 32'd0);
    pc = $urandom();
    do_dump("dump_after_reset");

    // Randomised steps then a run with a random halt point
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      pc = $urandom();
      busy_len = $urandom_range(1, 3);
      do_step("step_rand2");
    end
    pc = $urandom();
    do_run("run_halt_rand", $urandom_range(3, 20));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_controller.md
Name: pipeline_debug_controller

Overview:
Sequences the pipelined MIPS datapath from a byte-oriented host link (UART RX/TX).
- Gates the datapath through a single clock-enable, in continuous or single-step mode.
- Detects program halt and counts executed cycles.
- After every step or halt, dumps PC, cycle count, register bank and a window of data memory over the TX link.
- Sits between the UART pair and the datapath top; it is the only agent that enables pipeline advance.

Parameters:
NBITS, 32, datapath word width (PC, register and memory data)
RBITS, 5, register-bank address width
BANK_SIZE, 32, number of registers dumped
DMEM_WORDS, 32, number of data-memory words dumped, starting at word 0
MEMABITS, 10, data-memory word-address width

Ports:
i_clk  in  1  system clock; all state on rising edge
i_rst  in  1  asynchronous, active-high reset
i_rx_data  in  8  received command byte
i_rx_valid  in  1  one-cycle pulse; i_rx_data valid
o_tx_data  out  8  byte to transmit; stable from o_tx_start until i_tx_busy falls
o_tx_start  out  1  one-cycle transmit request
i_tx_busy  in  1  transmitter busy; raised no later than the cycle after o_tx_start
o_pipe_en  out  1  datapath clock-enable (PC, all pipeline registers, register bank, data memory writes)
i_halt  in  1  HALT instruction present in the WB stage
i_pc  in  NBITS  current PC
o_reg_addr  out  RBITS  register-bank debug read address
i_reg_data  in  NBITS  combinational register read data for o_reg_addr
o_mem_addr  out  MEMABITS  data-memory debug read address (word index)
i_mem_data  in  NBITS  combinational memory read data for o_mem_addr
o_halted  out  1  sticky: program has halted

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs go to 0.
  - State goes to IDLE; cycle counter, halted flag, byte and word indices are cleared.
  - Reset mid-RUN or mid-DUMP aborts with no further TX bytes.
- States: IDLE, RUN, STEP, DUMP_LOAD, DUMP_SEND, DUMP_WAIT.
- IDLE: o_pipe_en=0.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x44 'D' -> DUMP_LOAD.
  - 'C' and 'S' are ignored while o_halted=1.
  - All other bytes are ignored.
- RUN: o_pipe_en=1 every cycle.
  - If i_halt=1 in a cycle with o_pipe_en=1: o_pipe_en=0 from the next cycle, o_halted<=1, go to DUMP_LOAD.
  - RX bytes are ignored.
- STEP: o_pipe_en=1 for exactly one cycle, then DUMP_LOAD.
  - i_halt=1 in that cycle sets o_halted.
- Cycle counter: NBITS wide; increments on every cycle with o_pipe_en=1, including the halt cycle; wraps modulo 2^NBITS.
- Dump sequence, words in this order:
  - PC
  - cycle count
  - R0..R(BANK_SIZE-1)
  - M[0]..M[DMEM_WORDS-1]
  - Total bytes = 4*(2+BANK_SIZE+DMEM_WORDS); 264 at defaults.
- DUMP_LOAD:
  - Drives o_reg_addr / o_mem_addr for the current word index.
  - Captures the selected word (i_pc, counter, i_reg_data or i_mem_data) into a shift register in the same cycle.
- DUMP_SEND:
  - When i_tx_busy=0: pulse o_tx_start with o_tx_data = the word's MSB byte, then go to DUMP_WAIT.
- DUMP_WAIT:
  - Hold o_tx_data.
  - Skip the first cycle after the start pulse, then wait for i_tx_busy=0.
  - Then shift the word left 8 bits; next byte -> DUMP_SEND; after the 4th byte advance the word index -> DUMP_LOAD.
  - After the last word -> IDLE.
- Bytes within each word are sent MSB first.
- o_pipe_en=0 throughout the dump, so captured values are static.
- RX bytes received during a dump are dropped, not queued.
- o_tx_start is never asserted in two consecutive cycles.
- o_reg_addr and o_mem_addr hold their last value outside DUMP_LOAD.

Test Plan:
- Reset; send 'S' with i_pc=0x00000007:
  - o_pipe_en high exactly 1 cycle.
  - 264 bytes follow; bytes 1-4 = 00 00 00 07, bytes 5-8 = 00 00 00 01.
- Send 'C'; assert i_halt on the 10th enabled cycle:
  - o_pipe_en high exactly 10 cycles; o_halted=1.
  - Dumped cycle count = 0x0000000A.
- With o_halted=1, send 'C' then 'S':
  - o_pipe_en stays 0 and no TX activity.
  - Then 'D' produces a full 264-byte dump.
- Model register Rn=n*0x01010101 and M[k]=0xA0000000+k; hold i_tx_busy high 50 cycles per byte:
  - No o_tx_start while busy.
  - R3 sent as 03 03 03 03; M[31] sent as A0 00 00 1F.
  - Byte count exactly 264.
- Send 0x41 in IDLE and 'C' mid-dump:
  - Both ignored, with no o_pipe_en pulse.
  - Dump completes unchanged and the controller returns to IDLE.
- Assert i_rst asynchronously mid-dump (between clock edges):
  - All outputs 0 immediately and o_halted=0.
  - A subsequent 'D' restarts at the PC word with cycle count 0.
